// File: rtl/tx_handshake_mc.sv
// Multi-channel router-core to TX handshake: round-robin input arbitration into
// a small FIFO, drained one word per TX transmission via the valid/ready level protocol.
module tx_handshake_mc #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        rc_has_data,
  input  logic [NUM_CH*DATA_W-1:0] rc_data,
  output logic [NUM_CH-1:0]        tx_ready,
  input  logic                     TX_Data_Ready,
  output logic                     TX_Data_Valid,
  output logic [DATA_W-1:0]        TX_Data,
  output logic [CH_W-1:0]          TX_Ch,
  output logic [CNT_W-1:0]         fifo_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic [CH_W-1:0]   mem_ch_q   [DEPTH];
  logic [CH_W-1:0]   mem_ch_d   [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  int unsigned       scan_idx;
  logic              full;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_word;

  // First requester at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      scan_idx = (32'(rr_ptr_q) + k) % NUM_CH;
      if (!grant_found && rc_has_data[CH_W'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(scan_idx);
      end
    end
  end

  assign full = (count_q == CNT_W'(DEPTH));
  assign push = grant_found && !full;

  always_comb begin
    tx_ready = '0;
    if (push) tx_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    push_word = rc_data[grant_idx*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_SYNC: if (TX_Data_Ready) state_d = ST_IDLE;
      ST_IDLE: if (count_q != '0) state_d = ST_XFER;
      ST_XFER: begin
        // Falling TX_Data_Ready means the TX unit has taken the word.
        if (!TX_Data_Ready) begin
          pop     = 1'b1;
          state_d = ST_SYNC;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    mem_data_d = mem_data_q;
    mem_ch_d   = mem_ch_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rr_ptr_d   = rr_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_data_d[wr_ptr_q] = push_word;
      mem_ch_d[wr_ptr_q]   = grant_idx;
      wr_ptr_d             = wr_ptr_q + 1'b1;
      rr_ptr_d             = CH_W'((32'(grant_idx) + 1) % NUM_CH);
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SYNC;
      mem_data_q <= '{default: '0};
      mem_ch_q   <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_data_q <= mem_data_d;
      mem_ch_q   <= mem_ch_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rr_ptr_q   <= rr_ptr_d;
      count_q    <= count_d;
    end
  end

  assign TX_Data_Valid = (state_q == ST_XFER);
  assign TX_Data       = mem_data_q[rd_ptr_q];
  assign TX_Ch         = mem_ch_q[rd_ptr_q];
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_tx_handshake_mc.sv
// Directed bench for tx_handshake_mc: vector table for the per-cycle behaviour,
// hand sequences for simultaneous push/pop and asynchronous reset mid-transfer.
module tb_tx_handshake_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rc_has_data = '0;
  logic [31:0] rc_data = '0;
  logic [3:0]  tx_ready;
  logic        TX_Data_Ready = 1'b0;
  logic        TX_Data_Valid;
  logic [7:0]  TX_Data;
  logic [1:0]  TX_Ch;
  logic [2:0]  fifo_count;

  int n_vec = 0;
  int n_err = 0;

  tx_handshake_mc #(.NUM_CH(4), .DATA_W(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rc_has_data  (rc_has_data),
    .rc_data      (rc_data),
    .tx_ready     (tx_ready),
    .TX_Data_Ready(TX_Data_Ready),
    .TX_Data_Valid(TX_Data_Valid),
    .TX_Data      (TX_Data),
    .TX_Ch        (TX_Ch),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n;
    logic [3:0]  hd;
    logic [31:0] data;
    logic        txr;
    logic [3:0]  e_rdy;
    logic        e_v;
    logic [7:0]  e_d;
    logic [1:0]  e_ch;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [3:0] hd, input logic [31:0] d,
                     input logic txr, input logic [3:0] er, input logic ev,
                     input logic [7:0] ed, input logic [1:0] ec, input logic [2:0] en);
    vec_t v;
    v = '{r, hd, d, txr, er, ev, ed, ec, en};
    tv.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input logic r, input logic [3:0] hd, input logic [31:0] d,
                      input logic txr);
    @(negedge clk);
    rst_n         = r;
    rc_has_data   = hd;
    rc_data       = d;
    TX_Data_Ready = txr;
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] er, input logic ev,
                     input logic [7:0] ed, input logic [1:0] ec, input logic [2:0] en);
    logic [17:0] act, exp;
    act = {tx_ready, TX_Data_Valid, TX_Data, TX_Ch, fifo_count};
    exp = {er, ev, ed, ec, en};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy=%b v=%b d=%h ch=%0d cnt=%0d, want rdy=%b v=%b d=%h ch=%0d cnt=%0d",
               nm, tx_ready, TX_Data_Valid, TX_Data, TX_Ch, fifo_count, er, ev, ed, ec, en);
    end
  endtask

  localparam logic [31:0] DA = 32'h00A5_0000;
  localparam logic [31:0] DB = 32'h1312_1110;
  localparam logic [31:0] DC = 32'hD3C2_B1A0;
  localparam logic [31:0] DD = 32'h4433_2211;

  initial begin
    // single word on ch2, latency and pop on TX_Data_Ready fall
    add(0, 4'b0000, 0,  0, 4'b0000, 0, 8'h00, 0, 0);
    add(1, 4'b0000, 0,  1, 4'b0000, 0, 8'h00, 0, 0);
    add(1, 4'b0100, DA, 1, 4'b0100, 0, 8'h00, 0, 0);
    add(1, 4'b0000, DA, 1, 4'b0000, 0, 8'hA5, 2, 1);
    add(1, 4'b0000, DA, 1, 4'b0000, 1, 8'hA5, 2, 1);
    add(1, 4'b0000, DA, 0, 4'b0000, 1, 8'hA5, 2, 1);
    add(1, 4'b0000, DA, 0, 4'b0000, 0, 8'h00, 0, 0);
    // all channels requesting: round robin fill, full, re-grant after pop
    add(0, 4'b0000, DB, 0, 4'b0000, 0, 8'h00, 0, 0);
    add(1, 4'b1111, DB, 1, 4'b0001, 0, 8'h00, 0, 0);
    add(1, 4'b1111, DB, 1, 4'b0010, 0, 8'h10, 0, 1);
    add(1, 4'b1111, DB, 1, 4'b0100, 1, 8'h10, 0, 2);
    add(1, 4'b1111, DB, 1, 4'b1000, 1, 8'h10, 0, 3);
    add(1, 4'b1111, DB, 1, 4'b0000, 1, 8'h10, 0, 4);
    add(1, 4'b1111, DB, 0, 4'b0000, 1, 8'h10, 0, 4);
    add(1, 4'b1111, DB, 0, 4'b0001, 0, 8'h11, 1, 3);
    add(1, 4'b0000, DB, 0, 4'b0000, 0, 8'h11, 1, 4);
    // rr_ptr=2 wrap-around fairness, TX held not-ready while filling
    add(0, 4'b0000, DC, 0, 4'b0000, 0, 8'h00, 0, 0);
    add(1, 4'b0010, DC, 0, 4'b0010, 0, 8'h00, 0, 0);
    add(1, 4'b1001, DC, 0, 4'b1000, 0, 8'hB1, 1, 1);
    add(1, 4'b1001, DC, 0, 4'b0001, 0, 8'hB1, 1, 2);
    add(1, 4'b1001, DC, 0, 4'b1000, 0, 8'hB1, 1, 3);
    add(1, 4'b1001, DC, 0, 4'b0000, 0, 8'hB1, 1, 4);
    add(1, 4'b0000, DC, 0, 4'b0000, 0, 8'hB1, 1, 4);

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst_n, tv[i].hd, tv[i].data, tv[i].txr);
      chk($sformatf("vec%0d", i), tv[i].e_rdy, tv[i].e_v, tv[i].e_d, tv[i].e_ch, tv[i].e_cnt);
    end

    // simultaneous push and pop with two words buffered
    step(0, 4'b0000, DD, 0); chk("pp_rst",   4'b0000, 0, 8'h00, 0, 0);
    step(1, 4'b0001, DD, 0); chk("pp_push0", 4'b0001, 0, 8'h00, 0, 0);
    step(1, 4'b0010, DD, 0); chk("pp_push1", 4'b0010, 0, 8'h11, 0, 1);
    step(1, 4'b0000, DD, 1); chk("pp_sync",  4'b0000, 0, 8'h11, 0, 2);
    step(1, 4'b0000, DD, 1); chk("pp_idle",  4'b0000, 0, 8'h11, 0, 2);
    step(1, 4'b0100, DD, 0); chk("pp_both",  4'b0100, 1, 8'h11, 0, 2);
    step(1, 4'b0000, DD, 0); chk("pp_cnt",   4'b0000, 0, 8'h22, 1, 2);
    step(1, 4'b0000, DD, 1); chk("pp_sync2", 4'b0000, 0, 8'h22, 1, 2);
    step(1, 4'b0000, DD, 1); chk("pp_idle2", 4'b0000, 0, 8'h22, 1, 2);
    step(1, 4'b1000, DD, 1); chk("pp_xfer2", 4'b1000, 1, 8'h22, 1, 2);
    step(1, 4'b0000, DD, 1); chk("pp_three", 4'b0000, 1, 8'h22, 1, 3);

    // asynchronous reset in XFER with three words buffered
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 4'b0000, 0, 8'h00, 0, 0);
    step(1, 4'b0000, DD, 0); chk("post_rst",  4'b0000, 0, 8'h00, 0, 0);
    step(1, 4'b0010, DD, 0); chk("post_push", 4'b0010, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'b0000, DD, 0); chk($sformatf("sync_hold%0d", i), 4'b0000, 0, 8'h22, 1, 1);
    end
    step(1, 4'b0000, DD, 1); chk("sync_go",  4'b0000, 0, 8'h22, 1, 1);
    step(1, 4'b0000, DD, 1); chk("idle_go",  4'b0000, 0, 8'h22, 1, 1);
    step(1, 4'b0000, DD, 1); chk("xfer_go",  4'b0000, 1, 8'h22, 1, 1);
    step(1, 4'b0000, DD, 0); chk("xfer_end", 4'b0000, 1, 8'h22, 1, 1);
    step(1, 4'b0000, DD, 0); chk("drained",  4'b0000, 0, 8'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
